// File: rtl/mat_4x4_stream_sequencer_if.sv
// Stream link between the matrix sequencer and its environment.
// Bundles the operand input channel and the result output channel.
//   in_valid/in_ready/in_data       : 4-bit operand beats, A then B, row-major
//   out_valid/out_ready/out_data    : 8-bit result beats, row-major
//   out_last                        : marks result element 15
// The sequencer uses the slave modport; the environment that feeds
// operands and consumes results uses the master modport.
interface mat_4x4_stream_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mat_4x4_stream_sequencer.sv
// Sequential front/back end for a combinational 4x4 matrix multiplier.
// Collects 32 operand beats (A row-major, then B row-major) into the
// registers driving the multiplier, samples the 16 products in a single
// CALC cycle, then streams them out one byte per beat.
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   stream   : operand/result handshake link (slave side)
//   a_flat   : registered A, element k at [4k+3:4k]
//   b_flat   : registered B, element k at [4k+3:4k]
//   res_flat : multiplier products, element k at [8k+7:8k]
//   busy     : a transaction is in progress
module mat_4x4_stream_sequencer (
  input  logic                               clk,
  input  logic                               rst_n,
  mat_4x4_stream_sequencer_if.slave          stream,
  output logic [63:0]                        a_flat,
  output logic [63:0]                        b_flat,
  input  logic [127:0]                       res_flat,
  output logic                               busy
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     ld_cnt_q, ld_cnt_d;
  logic [3:0]     rd_idx_q, rd_idx_d;
  logic [63:0]    a_q, a_d;
  logic [63:0]    b_q, b_d;
  logic [127:0]   res_q, res_d;
  logic           in_hs;
  logic           out_hs;

  assign in_hs  = stream.in_valid  && (state_q == LOAD);
  assign out_hs = stream.out_ready && (state_q == DRAIN);

  // Next-state logic. ld_cnt wraps naturally from 31 back to 0, which is
  // exactly the reset-to-zero wanted when the last operand lands.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    rd_idx_d = rd_idx_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (ld_cnt_q[4] == 1'b0) begin
            a_d[{ld_cnt_q[3:0], 2'b00} +: 4] = stream.in_data;
          end else begin
            b_d[{ld_cnt_q[3:0], 2'b00} +: 4] = stream.in_data;
          end
          ld_cnt_d = ld_cnt_q + 5'd1;
          if (ld_cnt_q == 5'd31) begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Operands have been stable for this whole cycle, so the
        // multiplier output is settled when sampled here.
        res_d    = res_flat;
        rd_idx_d = 4'd0;
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (out_hs) begin
          rd_idx_d = rd_idx_q + 4'd1;
          if (rd_idx_q == 4'd15) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      ld_cnt_q <= 5'd0;
      rd_idx_q <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      rd_idx_q <= rd_idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
    end
  end

  // Outputs decode directly from registers, so they are glitch-free and
  // hold steady under output backpressure.
  assign stream.in_ready  = (state_q == LOAD);
  assign stream.out_valid = (state_q == DRAIN);
  assign stream.out_data  = res_q[{rd_idx_q, 3'b000} +: 8];
  assign stream.out_last  = (state_q == DRAIN) && (rd_idx_q == 4'd15);
  assign busy             = (state_q != LOAD) || (ld_cnt_q != 5'd0);
  assign a_flat           = a_q;
  assign b_flat           = b_q;

endmodule

// File: doc/mat_4x4_stream_sequencer.md
# mat_4x4_stream_sequencer

Sequential front/back end for the combinational `mat_4x4_multiplier`. Accepts the two 4x4 operand matrices as a serial stream of 4-bit elements, holds them in registers that drive the multiplier, captures the 16 8-bit products in one cycle, and streams the results out one byte per beat. It is the producer and consumer for the multiplier, so the array can sit behind a narrow valid/ready link.

## Interface
- Parameters: none. Operand width is fixed at 4 bits, result width at 8 bits, and matrix dimension at 4.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  sequencer can accept an operand beat.
- `in_data`  in  4  operand element. Order is A row-major (elements a..p), then B row-major (a1..p1): 32 beats in total.
- `a_flat`  out  64  registered A to the multiplier; element k (0 = a, 15 = p) sits at [4k+3:4k].
- `b_flat`  out  64  registered B to the multiplier; element k (0 = a1, 15 = p1) sits at [4k+3:4k].
- `res_flat`  in  128  multiplier results in row-major order: element k at [8k+7:8k], where q=0, r=1, s=2, t=3, u=4 … b2=11, c2=12, d2=13, e2=14, f2=15.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts the result beat.
- `out_data`  out  8  result element, row-major order.
- `out_last`  out  1  high with result element 15 only.
- `busy`  out  1  high while a transaction is in progress.

## Operation
- The FSM has three states: LOAD, CALC and DRAIN.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid` & `in_ready`) writes `in_data` into operand slot `ld_cnt` and then increments `ld_cnt`, a 5-bit counter running 0..31.
  - Slots 0..15 go to A; slots 16..31 go to B.
  - A handshake at `ld_cnt` = 31 moves the FSM to CALC and resets `ld_cnt` to 0.
- **CALC** (exactly one cycle)
  - `in_ready` = 0 and `out_valid` = 0.
  - `res_flat` is sampled into 16 result registers at the end of this cycle.
  - The FSM then moves to DRAIN with `rd_idx` = 0.
- **DRAIN**
  - `out_valid` = 1 and `out_data` = result[`rd_idx`].
  - Each handshake increments `rd_idx`.
  - A handshake at `rd_idx` = 15 returns the FSM to LOAD.
- `out_last` = (state == DRAIN) & (`rd_idx` == 15).
- `busy` = (state != LOAD) | (`ld_cnt` != 0).
- Arithmetic: the sequencer performs none. Results are passed through exactly as the multiplier produces them, i.e. every sum is taken mod 256, so overflow wraps with no flag.
- `a_flat`/`b_flat` keep their values after CALC until they are overwritten slot by slot in the next LOAD. Results are already captured by then, so partial overwrites do not corrupt the output.
- `in_valid` while `in_ready` = 0 is ignored; nothing is stored and no counter moves.
- `in_data` is don't-care whenever no handshake occurs.

## Timing
- Reset (`rst_n` low, asynchronous), with the values held while `rst_n` is low:
  - state = LOAD, `ld_cnt` = 0, `rd_idx` = 0.
  - `a_flat` = 0, `b_flat` = 0, all result registers = 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `busy` = 0.
- Reset mid-transaction, in any state: all partial operands and results are discarded. The block restarts at LOAD slot 0 on the first edge after `rst_n` rises.
- Latency: if the 32nd operand handshake is at edge T, CALC occupies cycle T..T+1 and `out_valid` first rises after edge T+1. There is one idle cycle between the last input beat and the first output beat.
- Output backpressure: while `out_valid` = 1 and `out_ready` = 0, `out_data`/`out_last` hold stable. `out_valid` never drops before its handshake.
- Throughput with no stalls: 32 + 1 + 16 = 49 cycles per transaction.
- The last output handshake at edge U sets `in_ready` = 1 after U. Input and output phases never overlap.
- The multiplier path, from `a_flat`/`b_flat` to `res_flat`, must settle within one clock period. It has at least one full cycle: the CALC cycle.

## Test plan
- Reset check: assert `rst_n` low mid-cycle. All outputs go immediately to their reset values (`in_ready` = 1, `out_valid` = 0, `busy` = 0, `a_flat` = `b_flat` = 0).
- Identity × ramp:
  - Stimulus: A = I (1 on the diagonal, 0 elsewhere), B element k = k mod 16, no stalls.
  - Required response: `out_data` = 0,1,…,15; `out_last` only on 15; first `out_valid` exactly 2 edges after the 32nd input handshake.
- Overflow wrap:
  - Stimulus: A and B all 15.
  - Required response: every result = 4 × 225 mod 256 = 132 (0x84), giving 16 beats of 0x84.
- Input gaps and output stalls:
  - Stimulus: random `in_valid` gaps, and `out_ready` held low for 5 cycles on beat 7.
  - Required response: results match a reference model; `out_data` stays stable during the stall; `in_valid` pulses during CALC/DRAIN have no effect.
- Mid-load reset: load 20 beats, pulse `rst_n` low, then load a full identity × all-2s transaction. The outputs are sixteen 2s, and no stale operands appear.
- Back-to-back transactions: two transactions with different data and `out_ready` tied high. The second transaction's results are correct, and `busy` is 1 from the first input handshake of each transaction through its last output handshake.
